// File: rtl/spi_csr_bridge.sv
// SPI mode-0 slave, oversampled in the clk domain, issuing single-cycle CSR reads/writes.
// Define SPI_ADDR_INC_EN to auto-increment csr_address after each data-byte access.
module spi_csr_bridge #(
   parameter int A_WIDTH     = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               nss,
   input  logic               sck,
   input  logic               mosi,
   output logic               miso,
   output logic               miso_oe,
   output logic               chip_select,
   output logic [A_WIDTH-1:0] csr_address,
   output logic               csr_read,
   input  logic [7:0]         csr_readdata,
   output logic               csr_write,
   output logic [7:0]         csr_writedata
);

   typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

   state_t               state_q, state_d;
   logic [SYNC_STAGES-1:0] nss_sync_q, sck_sync_q, mosi_sync_q;
   logic                 nss_prev_q, sck_prev_q;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic                 miso_oe_q, miso_oe_d;
   logic                 cs_q, cs_d;
   logic                 rd_q, rd_d;
   logic                 wr_q, wr_d;
   logic                 rd_pend_q;
   logic                 hold_q, hold_d;
   logic [A_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic [6:0]           rx_q;
   logic [7:0]           tx_q;

   logic       nss_s, sck_s, mosi_s;
   logic       nss_fall, nss_rise, sck_rise, sck_fall, byte_done;
   logic [7:0] rx_byte;

   assign nss_s     = nss_sync_q[SYNC_STAGES-1];
   assign sck_s     = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign nss_fall  = nss_prev_q & ~nss_s;
   assign nss_rise  = ~nss_prev_q & nss_s;
   assign sck_rise  = sck_s & ~sck_prev_q;
   assign sck_fall  = ~sck_s & sck_prev_q;
   assign rx_byte   = {rx_q, mosi_s};
   assign byte_done = (state_q != IDLE) && sck_rise && (bit_cnt_q == 3'd7);

   // nss chain resets low so a reset taken mid-transaction cannot fake an nss fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nss_sync_q  <= '0;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         nss_prev_q  <= 1'b0;
         sck_prev_q  <= 1'b0;
      end else begin
         nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], nss};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         nss_prev_q  <= nss_s;
         sck_prev_q  <= sck_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         miso_oe_q <= 1'b0;
         cs_q      <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         rd_pend_q <= 1'b0;
         hold_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         miso_oe_q <= miso_oe_d;
         cs_q      <= cs_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         rd_pend_q <= rd_q;
         hold_q    <= hold_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      miso_oe_d = miso_oe_q;
      cs_d      = cs_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      hold_d    = hold_q;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      if (nss_rise) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         cs_d      = 1'b0;
         miso_oe_d = 1'b0;
         hold_d    = 1'b0;
      end else if (state_q == IDLE) begin
         bit_cnt_d = '0;
         hold_d    = 1'b0;
         if (nss_fall) begin
            state_d   = CMD;
            miso_oe_d = 1'b1;
         end
      end else begin
         if (sck_rise) bit_cnt_d = bit_cnt_q + 3'd1;
         if (sck_fall) hold_d = 1'b0;
`ifdef SPI_ADDR_INC_EN
         if (wr_q) addr_d = addr_q + 1'b1;
`endif
         if (byte_done) begin
            // The fall right after a completed byte keeps the freshly loaded MSB on miso.
            hold_d = 1'b1;
            case (state_q)
               CMD: begin
                  addr_d = rx_byte[A_WIDTH-1:0];
                  cs_d   = 1'b1;
                  if (rx_byte[7]) begin
                     state_d = WDATA;
                  end else begin
                     rd_d    = 1'b1;
                     state_d = RDATA;
                  end
               end
               WDATA: begin
                  wr_d    = 1'b1;
                  wdata_d = rx_byte;
               end
               RDATA: begin
                  rd_d = 1'b1;
`ifdef SPI_ADDR_INC_EN
                  addr_d = addr_q + 1'b1;
`endif
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q != IDLE) && sck_rise) rx_q <= rx_byte[6:0];
      if (rd_pend_q) tx_q <= csr_readdata;
      else if ((state_q == RDATA) && sck_fall && !hold_q) tx_q <= {tx_q[6:0], 1'b0};
   end

   assign miso          = (state_q == RDATA) & tx_q[7];
   assign miso_oe       = miso_oe_q;
   assign chip_select   = cs_q;
   assign csr_address   = addr_q;
   assign csr_read      = rd_q;
   assign csr_write     = wr_q;
   assign csr_writedata = wdata_q;

endmodule
